mulpop_bus_master: RTL

Bus-master sequencer that sits directly upstream of the GPIO multiply/popcount emulator slave and drives its `saddress`/`srd`/`swr` register bus. It accepts 24-bit operand pairs on a valid/ready job port, writes them to the slave, starts the operation, polls status, reads back the product word and ones count, and presents them on a valid/ready result port. One job is in flight at a time.

---
 rtl/mulpop_pkg.sv | 67 ++++++
 rtl/mulpop_bus_master_if.sv | 35 +++
 rtl/sbus_cycle.sv | 67 ++++++
 rtl/mulpop_bus_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mulpop_pkg.sv
// Shared definitions for the mulpop bus master: slave register map, FSM states,
// status bit positions and the bus request payload.
package mulpop_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPND_W = 24;

  localparam logic [ADDR_W-1:0] REG_A1   = 16'h037F;
  localparam logic [ADDR_W-1:0] REG_A2   = 16'h0388;
  localparam logic [ADDR_W-1:0] REG_GO   = 16'h03A1;
  localparam logic [ADDR_W-1:0] REG_STAT = 16'h03A0;
  localparam logic [ADDR_W-1:0] REG_W    = 16'h0390;
  localparam logic [ADDR_W-1:0] REG_L    = 16'h0398;

  localparam int unsigned STAT_READY = 1;
  localparam int unsigned STAT_VALID = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_SETTLE,
    ST_POLL,
    ST_RD_W,
    ST_RD_L,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Bus cycle issued on behalf of a given FSM state; status poll is the fallback.
  function automatic bus_req_t bus_req_for(input state_e st,
                                           input logic [OPND_W-1:0] a1,
                                           input logic [OPND_W-1:0] a2);
    bus_req_t r;
    r.rd    = 1'b1;
    r.addr  = REG_STAT;
    r.wdata = '0;
    case (st)
      ST_WR_A1: begin
        r.rd    = 1'b0;
        r.addr  = REG_A1;
        r.wdata = {{(DATA_W-OPND_W){1'b0}}, a1};
      end
      ST_WR_A2: begin
        r.rd    = 1'b0;
        r.addr  = REG_A2;
        r.wdata = {{(DATA_W-OPND_W){1'b0}}, a2};
      end
      ST_WR_GO: begin
        r.rd   = 1'b0;
        r.addr = REG_GO;
      end
      ST_RD_W: r.addr = REG_W;
      ST_RD_L: r.addr = REG_L;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mulpop_bus_master_if.sv
// Job, result and slave register bus signals of the mulpop bus master.
interface mulpop_bus_master_if;
  import mulpop_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [OPND_W-1:0] job_a1;
  logic [OPND_W-1:0] job_a2;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_w;
  logic [OPND_W-1:0] res_ones;
  logic              res_ovf;
  logic              res_err;

  logic [ADDR_W-1:0] saddress;
  logic              srd;
  logic              swr;
  logic [DATA_W-1:0] sdata_out;
  logic [DATA_W-1:0] sdata_in;

  modport master (
    input  job_valid, job_a1, job_a2, res_ready, sdata_in,
    output job_ready, res_valid, res_w, res_ones, res_ovf, res_err,
    output saddress, srd, swr, sdata_out
  );

  modport slave (
    output job_valid, job_a1, job_a2, res_ready, sdata_in,
    input  job_ready, res_valid, res_w, res_ones, res_ovf, res_err,
    input  saddress, srd, swr, sdata_out
  );

endinterface

// File: rtl/sbus_cycle.sv
// One slave register bus cycle: address phase, STROBE_CYC strobe-high cycles,
// release cycle with done; a new start in the release cycle chains with no gap.
module sbus_cycle
  import mulpop_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] saddress,
  output logic              srd,
  output logic              swr,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [DATA_W-1:0] sdata_in
);

  localparam int unsigned     PH_W    = $clog2(STROBE_CYC + 2);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(STROBE_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STROBE_CYC + 1);

  logic [PH_W-1:0] ph;
  logic            rd_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ph        <= '0;
      rd_q      <= 1'b0;
      rdata     <= '0;
      saddress  <= '0;
      srd       <= 1'b0;
      swr       <= 1'b0;
      sdata_out <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        ph        <= '0;
        rd_q      <= rw;
        saddress  <= addr;
        sdata_out <= wdata;
        srd       <= 1'b0;
        swr       <= 1'b0;
      end else if (busy) begin
        if (ph == PH_LAST) begin
          busy <= 1'b0;
        end else begin
          // Strobe is high for phases 1..STROBE_CYC; data sampled at the end of the last one.
          ph   <= ph + PH_W'(1);
          srd  <= rd_q && (ph < PH_HI);
          swr  <= !rd_q && (ph < PH_HI);
          done <= (ph == PH_HI);
          if (ph == PH_HI) rdata <= sdata_in;
        end
      end
    end
  end

endmodule

// File: rtl/mulpop_bus_master.sv
// Sequencer driving the multiply/popcount slave: write operands, start, poll,
// read product and ones count. Define MULPOP_TIMEOUT_EN to bound polling by POLL_MAX.
module mulpop_bus_master
  import mulpop_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 8
`ifdef MULPOP_TIMEOUT_EN
  ,
  parameter int unsigned POLL_MAX   = 16
`endif
) (
  input logic                 clk,
  input logic                 n_reset,
  mulpop_bus_master_if.master bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 2);

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [OPND_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic              job_ready_q, job_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              res_ovf_q, res_ovf_d;
  logic [DATA_W-1:0] res_w_q, res_w_d;
  logic [OPND_W-1:0] res_ones_q, res_ones_d;

  logic              issue_c;
  state_e            issue_st_c;
  bus_req_t          req_c;
  logic              bus_done;
  logic              bus_busy;
  logic [DATA_W-1:0] bus_rdata;

`ifdef MULPOP_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              res_err_q, res_err_d;
`endif

  // Next-state and next-output logic; bus cycles are launched in the edge that
  // enters their state so consecutive cycles run back to back.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    res_valid_d = res_valid_q;
    res_ovf_d   = res_ovf_q;
    res_w_d     = res_w_q;
    res_ones_d  = res_ones_q;
    issue_c     = 1'b0;
    issue_st_c  = state_q;
`ifdef MULPOP_TIMEOUT_EN
    poll_d      = poll_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.job_valid) begin
          state_d = ST_WR_A1;
          a1_d    = bus.job_a1;
          a2_d    = bus.job_a2;
`ifdef MULPOP_TIMEOUT_EN
          res_err_d = 1'b0;
`endif
        end
      end
      ST_WR_A1: begin
        if (!bus_busy) issue_c = 1'b1;
        if (bus_done) begin
          state_d    = ST_WR_A2;
          issue_c    = 1'b1;
          issue_st_c = ST_WR_A2;
        end
      end
      ST_WR_A2: begin
        if (bus_done) begin
          state_d    = ST_WR_GO;
          issue_c    = 1'b1;
          issue_st_c = ST_WR_GO;
        end
      end
      ST_WR_GO: begin
        if (bus_done) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (32'(settle_q) + 32'd1 >= SETTLE_CYC) begin
          state_d    = ST_POLL;
          issue_c    = 1'b1;
          issue_st_c = ST_POLL;
`ifdef MULPOP_TIMEOUT_EN
          poll_d     = '0;
`endif
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_POLL: begin
        if (bus_done) begin
          if (bus_rdata[STAT_READY]) begin
            res_ovf_d  = ~bus_rdata[STAT_VALID];
            state_d    = ST_RD_W;
            issue_c    = 1'b1;
            issue_st_c = ST_RD_W;
          end else begin
`ifdef MULPOP_TIMEOUT_EN
            if (32'(poll_q) + 32'd1 >= POLL_MAX) begin
              state_d     = ST_OUT;
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
              res_w_d     = '0;
              res_ones_d  = '0;
              res_ovf_d   = 1'b0;
            end else begin
              poll_d  = poll_q + POLL_W'(1);
              issue_c = 1'b1;
            end
`else
            issue_c = 1'b1;
`endif
          end
        end
      end
      ST_RD_W: begin
        if (bus_done) begin
          res_w_d    = bus_rdata;
          state_d    = ST_RD_L;
          issue_c    = 1'b1;
          issue_st_c = ST_RD_L;
        end
      end
      ST_RD_L: begin
        if (bus_done) begin
          res_ones_d  = bus_rdata[OPND_W-1:0];
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    job_ready_d = (state_d == ST_IDLE);
  end

  assign req_c = bus_req_for(issue_st_c, a1_q, a2_q);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      job_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_w_q     <= '0;
      res_ones_q  <= '0;
`ifdef MULPOP_TIMEOUT_EN
      poll_q      <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      job_ready_q <= job_ready_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
      res_w_q     <= res_w_d;
      res_ones_q  <= res_ones_d;
`ifdef MULPOP_TIMEOUT_EN
      poll_q      <= poll_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  sbus_cycle #(
    .STROBE_CYC(STROBE_CYC)
  ) u_sbus (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (issue_c),
    .rw        (req_c.rd),
    .addr      (req_c.addr),
    .wdata     (req_c.wdata),
    .done      (bus_done),
    .busy      (bus_busy),
    .rdata     (bus_rdata),
    .saddress  (bus.saddress),
    .srd       (bus.srd),
    .swr       (bus.swr),
    .sdata_out (bus.sdata_out),
    .sdata_in  (bus.sdata_in)
  );

  assign bus.job_ready = job_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_w     = res_w_q;
  assign bus.res_ones  = res_ones_q;
  assign bus.res_ovf   = res_ovf_q;
`ifdef MULPOP_TIMEOUT_EN
  assign bus.res_err   = res_err_q;
`else
  assign bus.res_err   = 1'b0;
`endif

endmodule
